// File: rtl/esm_slot_scheduler_if.sv
// esm_slot_scheduler_if: producer/consumer handshake bundle for the ESM shuffling-buffer slot scheduler
interface esm_slot_scheduler_if #(parameter int BS = 16);
   localparam int IW = $clog2(BS);
   logic          flush;
   logic          alloc_req;
   logic          alloc_gnt;
   logic [IW-1:0] alloc_idx;
   logic          issue_valid;
   logic          issue_ready;
   logic [IW-1:0] issue_idx;
   logic [IW:0]   count;
   logic          full;
   logic          empty;
   modport master (output flush, alloc_req, issue_ready,
                   input alloc_gnt, alloc_idx, issue_valid, issue_idx, count, full, empty);
   modport slave  (input flush, alloc_req, issue_ready,
                   output alloc_gnt, alloc_idx, issue_valid, issue_idx, count, full, empty);
endinterface

// File: rtl/esm_slot_scheduler.sv
// esm_slot_scheduler: lowest-free-slot allocator plus randomized drain order; random pick enabled by ESM_SCHED_RANDOM_EN
module esm_slot_scheduler #(
   parameter int          BS   = 16,
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input logic clk,
   input logic rst,
   esm_slot_scheduler_if.slave bus
);
   localparam int IW = $clog2(BS);
   localparam logic [31:0] TAPS = 32'h8020_0003;
   typedef enum logic [1:0] {IDLE, PICK, OFFER} state_t;
   state_t        state_q, state_d;
   logic [BS-1:0] occ_q, occ_d;
   logic [IW:0]   count_q, count_d, seen;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [IW-1:0] sel_q, sel_d, free_idx, kth_idx;
   logic [15:0]   k;
   logic          alloc_hs, issue_hs;
   assign bus.full        = count_q == (IW+1)'(BS);
   assign bus.empty       = count_q == '0;
   assign bus.count       = count_q;
   assign bus.alloc_gnt   = bus.alloc_req & ~bus.full;
   assign bus.alloc_idx   = free_idx;
   assign bus.issue_valid = state_q == OFFER;
   assign bus.issue_idx   = sel_q;
   assign alloc_hs        = bus.alloc_gnt & ~bus.flush;
   assign issue_hs        = bus.issue_valid & bus.issue_ready & ~bus.flush;
`ifdef ESM_SCHED_RANDOM_EN
   assign k = bus.empty ? 16'd0 : lfsr_q[15:0] % 16'(count_q);
`else
   assign k = 16'd0;
`endif
   // free_idx: priority encoder over ~occ; kth_idx: k-th set bit of occ from bit 0
   always_comb begin
      free_idx = '0;
      kth_idx  = '0;
      seen     = '0;
      for (int i = BS - 1; i >= 0; i--) free_idx = occ_q[i] ? free_idx : IW'(i);
      for (int i = 0; i < BS; i++) begin
         kth_idx = (occ_q[i] && 16'(seen) == k) ? IW'(i) : kth_idx;
         seen    = seen + (IW+1)'(occ_q[i]);
      end
   end
   always_comb begin
      lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      occ_d   = occ_q;
      occ_d   = alloc_hs ? (occ_d | (BS'(1) << free_idx)) : occ_d;
      occ_d   = issue_hs ? (occ_d & ~(BS'(1) << sel_q)) : occ_d;
      count_d = count_q + (IW+1)'(alloc_hs) - (IW+1)'(issue_hs);
      sel_d   = state_q == PICK ? kth_idx : sel_q;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.empty ? IDLE : PICK;
         PICK:    state_d = OFFER;
         default: state_d = issue_hs ? (count_d == '0 ? IDLE : PICK) : OFFER;
      endcase
      occ_d   = bus.flush ? '0 : occ_d;
      count_d = bus.flush ? '0 : count_d;
      state_d = bus.flush ? IDLE : state_d;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         occ_q   <= '0;
         count_q <= '0;
         lfsr_q  <= SEED;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         count_q <= count_d;
         lfsr_q  <= lfsr_d;
         sel_q   <= sel_d;
      end
endmodule

// File: tb/tb_esm_slot_scheduler.sv
// tb_esm_slot_scheduler: randomized scoreboard bench with a slot-level reference model of the scheduler
module tb_esm_slot_scheduler;
   localparam int          BS   = 16;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   esm_slot_scheduler_if #(.BS(BS)) bus();
   esm_slot_scheduler #(.BS(BS), .SEED(SEED)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   // model state (m_*) and its copy from the previous cycle (s_*), which is what a pick sees
   bit          m_occ[BS];
   int          m_count = 0;
   logic [31:0] m_lfsr  = SEED;
   bit          s_occ[BS];
   int          s_count = 0;
   logic [31:0] s_lfsr  = SEED;
   int          offer_idx = 0;
   bit          prev_valid = 0;
   int          cyc = 0;
   typedef struct {bit gnt; int idx;} alloc_t;
   alloc_t exp_alloc[$];
   int     issued[$];
   int     issued_cyc[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < BS; i++) if (!m_occ[i]) return i;
      return 0;
   endfunction

   function automatic int pick_expected();
      int k;
      int seen = 0;
      if (s_count == 0) return -1;
`ifdef ESM_SCHED_RANDOM_EN
      k = int'(s_lfsr[15:0]) % s_count;
`else
      k = 0;
`endif
      for (int i = 0; i < BS; i++)
         if (s_occ[i]) begin
            if (seen == k) return i;
            seen++;
         end
      return -1;
   endfunction

   task automatic model_step();
      bit a;
      bit i;
      if (rst) begin
         foreach (m_occ[j]) begin m_occ[j] = 0; s_occ[j] = 0; end
         m_count = 0; s_count = 0;
         m_lfsr = SEED; s_lfsr = SEED;
         exp_alloc.delete();
         return;
      end
      cyc++;
      s_occ = m_occ; s_count = m_count; s_lfsr = m_lfsr;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
      if (bus.flush) begin
         foreach (m_occ[j]) m_occ[j] = 0;
         m_count = 0;
      end else begin
         a = bus.alloc_req && m_count < BS;
         i = bus.issue_valid && bus.issue_ready;
         if (a) m_occ[lowest_free()] = 1;
         if (i) m_occ[offer_idx] = 0;
         m_count = m_count + int'(a) - int'(i);
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   // monitor: pops alloc expectations, checks offers against the model, records handshakes
   always @(negedge clk) begin
      alloc_t e;
      if (rst) prev_valid = 0;
      else begin
         check("count", int'(bus.count), m_count);
         check("empty", int'(bus.empty), int'(m_count == 0));
         check("full", int'(bus.full), int'(m_count == BS));
         if (bus.alloc_req) begin
            if (exp_alloc.size() == 0) check("alloc_queue_underrun", 1, 0);
            else begin
               e = exp_alloc.pop_front();
               check("alloc_gnt", int'(bus.alloc_gnt), int'(e.gnt));
               if (e.gnt) check("alloc_idx", int'(bus.alloc_idx), e.idx);
            end
         end
         if (bus.issue_valid) begin
            if (!prev_valid) begin
               offer_idx = pick_expected();
               check("offer_idx", int'(bus.issue_idx), offer_idx);
            end else check("offer_stable", int'(bus.issue_idx), offer_idx);
            if (bus.issue_ready && !bus.flush) begin
               issued.push_back(int'(bus.issue_idx));
               issued_cyc.push_back(cyc);
            end
         end
         prev_valid = bus.issue_valid;
      end
   end

   task automatic step(input bit a, input bit r, input bit f);
      alloc_t e;
      @(posedge clk);
      #1;
      bus.alloc_req = a; bus.issue_ready = r; bus.flush = f;
      if (a) begin
         e.gnt = m_count < BS;
         e.idx = lowest_free();
         exp_alloc.push_back(e);
      end
   endtask

   task automatic wait_offer();
      for (int n = 0; n < 10; n++) begin
         step(0, 0, 0);
         @(negedge clk);
         if (bus.issue_valid) return;
      end
      check("wait_offer_timeout", 0, 1);
   endtask

   initial begin
      int base;
      int h;
      bit in_order;
      bit seen_idx[BS];
      bus.alloc_req = 0; bus.issue_ready = 0; bus.flush = 0;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      @(negedge clk);
      check("rst_count", int'(bus.count), 0);
      check("rst_empty", int'(bus.empty), 1);
      check("rst_full", int'(bus.full), 0);
      check("rst_valid", int'(bus.issue_valid), 0);
      check("rst_alloc_idx", int'(bus.alloc_idx), 0);
      // fill, then one request too many
      for (int i = 0; i < BS; i++) step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      @(negedge clk);
      check("fill_count", int'(bus.count), BS);
      check("fill_full", int'(bus.full), 1);
      check("fill_valid", int'(bus.issue_valid), 1);
      // drain
      base = issued.size();
      for (int n = 0; n < 60 && issued.size() < base + BS; n++) step(0, 1, 0);
      check("drain_issues", issued.size() - base, BS);
      if (issued.size() >= base + BS) begin
         in_order = 1;
         foreach (seen_idx[i]) seen_idx[i] = 0;
         for (int i = 0; i < BS; i++) begin
            h = issued[base + i];
            check("drain_unique", int'(seen_idx[h]), 0);
            seen_idx[h] = 1;
            if (h != i) in_order = 0;
            if (i > 0) check("drain_spacing", issued_cyc[base + i] - issued_cyc[base + i - 1], 2);
         end
`ifdef ESM_SCHED_RANDOM_EN
         check("drain_shuffled", int'(in_order), 0);
`else
         check("drain_in_order", int'(in_order), 1);
`endif
      end
      repeat (3) step(0, 0, 0);
      @(negedge clk);
      check("drain_empty", int'(bus.empty), 1);
      check("drain_idle", int'(bus.issue_valid), 0);
      // simultaneous alloc and issue
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      base = issued.size();
      for (int n = 0; n < 20 && issued.size() < base + 2; n++) step(0, 1, 0);
      wait_offer();
      step(1, 1, 0);
      step(0, 0, 0);
      @(negedge clk);
      check("simul_count", int'(bus.count), 4);
      wait_offer();
`ifndef ESM_SCHED_RANDOM_EN
      check("simul_next_offer", int'(bus.issue_idx), 0);
`endif
      // flush with a pending offer and a same-cycle alloc
      step(1, 0, 0);
      wait_offer();
      check("pre_flush_count", int'(bus.count), 5);
      step(1, 0, 1);
      step(0, 0, 0);
      @(negedge clk);
      check("flush_count", int'(bus.count), 0);
      check("flush_valid", int'(bus.issue_valid), 0);
      check("flush_alloc_idx", int'(bus.alloc_idx), 0);
      // asynchronous reset during an offer
      step(1, 0, 0);
      step(1, 0, 0);
      wait_offer();
      step(0, 1, 0);
      #1 rst = 1;
      #1;
      check("arst_valid", int'(bus.issue_valid), 0);
      check("arst_count", int'(bus.count), 0);
      bus.issue_ready = 0;
      #1 rst = 0;
      // randomized traffic
      for (int n = 0; n < 600; n++)
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2);
      step(0, 0, 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/esm_slot_scheduler.md
# esm_slot_scheduler

Randomized slot scheduler for the ESM shuffling buffer. It owns the occupancy map of a BS-entry data buffer and grants producer writes into the lowest free slot. It offers the consumer a randomly chosen occupied slot over a valid/ready handshake, so the buffer drains in an order that does not depend on arrival order. It sits between the buffer's write port and read port and drives both slot indices.

## Interface
- BS, 16, number of buffer slots; power of two, 2..64
- SEED, 32'hACE1_2468, LFSR reset value; must be nonzero
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of occupancy and scheduler state
- alloc_req  in  1  producer requests a slot for a write
- alloc_gnt  out  1  write granted this cycle; combinational, equals alloc_req & !full
- alloc_idx  out  $clog2(BS)  lowest-index free slot; valid when !full
- issue_valid  out  1  issue_idx holds an occupied slot for the consumer
- issue_ready  in  1  consumer accepts issue_idx
- issue_idx  out  $clog2(BS)  slot the consumer reads
- count  out  $clog2(BS)+1  number of occupied slots
- full  out  1  count == BS
- empty  out  1  count == 0

## Operation
- occ[BS-1:0]: occupancy register. On an alloc handshake, occ[alloc_idx] is set at the clock edge. On an issue handshake, occ[issue_idx] is cleared. Both can happen in the same cycle and always hit different slots.
- count is a registered counter, not a popcount:
  - +1 on alloc only
  - −1 on issue only
  - unchanged when both occur
- lfsr: 32-bit Galois LFSR, taps 32'h8020_0003, shifts right every cycle. It is not affected by flush.
- FSM states:
  - IDLE: issue_valid=0. Moves to PICK when count != 0.
  - PICK: issue_valid=0. Computes k = lfsr[15:0] % count and latches into sel_q the index of the k-th set bit of occ, counting from bit 0 upward. Moves to OFFER.
  - OFFER: issue_valid=1 and issue_idx=sel_q, held stable until issue_ready. On handshake: go to PICK if the post-update count != 0, else IDLE.
- PICK uses occ and count as registered values. A slot allocated in the same cycle as PICK is not eligible for that pick.
- flush: occ=0, count=0, FSM→IDLE, issue_valid deasserts the next cycle. flush takes priority over same-cycle alloc and issue handshakes, and neither takes effect.
- alloc_idx is a combinational priority encoder over ~occ. When full, it is 0 and alloc_gnt=0.

## Timing
- Reset values:
  - occ=0, count=0, empty=1, full=0
  - FSM=IDLE, issue_valid=0, issue_idx=0, sel_q=0
  - lfsr=SEED
- Reset asserted mid-operation restores all of the above immediately and drops any pending offer. No handshake completes in that cycle.
- Latency:
  - alloc handshake at edge N: count and occ update at N.
  - Empty buffer: first issue_valid two cycles after the first alloc edge (IDLE→PICK→OFFER).
  - Back-to-back issues: one issue every 2 cycles maximum (OFFER→PICK→OFFER).
- Once issue_valid is high, issue_idx must not change until the handshake, flush or reset.
- alloc_gnt has no registered dependency on issue_ready. A slot freed at edge N is allocatable from cycle N+1.

## Configuration
- ESM_SCHED_RANDOM_EN defined: PICK uses k = lfsr[15:0] % count as described.
- ESM_SCHED_RANDOM_EN undefined: PICK forces k=0, i.e. the lowest occupied slot. This is the deterministic debug mode. The LFSR is still instantiated and running; only the selection changes.

## Test plan
- Reset and idle, macro off: after rst, expect count=0, empty=1, issue_valid=0, alloc_idx=0. Pulse rst during OFFER → issue_valid=0 immediately.
- Fill to full, macro off: 16 alloc_req cycles → alloc_idx 0..15 in order, count=16, full=1. A 17th request gives alloc_gnt=0.
- Deterministic drain, macro off: from full with issue_ready=1 → issue_idx sequence 0,1,...,15, one every 2 cycles, ending with empty=1 and the FSM in IDLE.
- Simultaneous alloc and issue, macro off: occ=slots {2,5}, offer on 2, alloc_req and issue_ready in the same cycle → slot 0 granted, slot 2 freed, count stays 2, next offer is 0.
- Random order, macro on: bench LFSR model from SEED, fill 16 slots and drain → each issue_idx matches the model's k-th occupied slot. All 16 indices are issued exactly once, and the drain order is not 0..15.
- Flush: with 5 slots occupied and an offer pending, assert flush with a same-cycle alloc_req → next cycle count=0, issue_valid=0, occ=0.
